ucom_timer_bank: RTL and testbench

- Parametrised successor to the single STM/TTM timer inside the 4-bit MCU cores: NCH independent channels, each a PRE_W-bit prescaler feeding a CNT_W-bit down-counter.
- Per channel: one-shot or auto-reload mode, sticky TM flag, interrupt pending with overrun detection, and one shared interrupt request line.
- Sits beside the CPU core. The core issues load and acknowledge strobes on its clk_en cycles, samples tm for TTM-style skips, and routes irq to its interrupt input.

---
 rtl/ucom_timer_bank.sv | 123 ++++++++++++
 tb/tb_ucom_timer_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ucom_timer_bank.sv
`default_nettype none
// ============================================================================
// ucom_timer_bank : NCH prescaled down-counter timers with TM/IRQ/overrun flags
// Revision 1.0
// ============================================================================
module ucom_timer_bank #(
  parameter int NCH   = 2,
  parameter int CNT_W = 6,
  parameter int PRE_W = 6,
  parameter int CH_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             wr_mode,
  input  logic             wr_ie,
  input  logic             ack,
  input  logic [CH_W-1:0]  ack_ch,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [NCH-1:0]   tm,
  output logic [NCH-1:0]   run,
  output logic [NCH-1:0]   ovr,
  output logic             irq
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [NCH-1:0]            pend_v;
  logic [NCH-1:0][CNT_W-1:0] cnt_v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [PRE_W-1:0] pcount;
    logic [CNT_W-1:0] bcount;
    logic [CNT_W-1:0] reload;
    logic [0:0]       state;
    logic             mode;
    logic             ie;
    logic             tm_q;
    logic             pend;
    logic             ovr_q;
    logic             load_hit;
    logic             ack_hit;
    logic             expire;

    assign load_hit = wr && (wr_ch == IDX);
    assign ack_hit  = ack && (ack_ch == IDX);
    assign expire   = (state == RUN) && tick && (&pcount) && (bcount == '0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pcount <= '0;
        bcount <= '0;
        reload <= '0;
        state  <= IDLE;
        mode   <= 1'b0;
        ie     <= 1'b0;
        tm_q   <= 1'b0;
        pend   <= 1'b0;
        ovr_q  <= 1'b0;
      end else if (load_hit) begin
        // A load overrides any expiry or acknowledge landing in the same cycle
        pcount <= '0;
        bcount <= wr_val;
        reload <= wr_val;
        mode   <= wr_mode;
        ie     <= wr_ie;
        tm_q   <= 1'b0;
        pend   <= 1'b0;
        ovr_q  <= 1'b0;
        state  <= RUN;
      end else begin
        if (state == RUN && tick) begin
          pcount <= pcount + 1'b1;
          if (&pcount) begin
            if (bcount != '0) begin
              bcount <= bcount - 1'b1;
            end else begin
              tm_q <= 1'b1;
              if (mode) begin
                bcount <= reload;
              end else begin
                state  <= IDLE;
                pcount <= '0;
              end
            end
          end
        end
        // Expiry beats a coincident ack: pend stays set and ovr is left alone
        if (expire && ie) begin
          pend <= 1'b1;
          if (pend && !ack_hit) ovr_q <= 1'b1;
        end else if (ack_hit) begin
          pend  <= 1'b0;
          ovr_q <= 1'b0;
        end
      end
    end

    assign tm[i]     = tm_q;
    assign run[i]    = (state == RUN);
    assign ovr[i]    = ovr_q;
    assign pend_v[i] = pend;
    assign cnt_v[i]  = bcount;
  end

  assign irq = |pend_v;

  always_comb begin
    rd_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_ch == CH_W'(k)) rd_cnt = cnt_v[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucom_timer_bank.sv
`default_nettype none
// ============================================================================
// tb_ucom_timer_bank : directed self-checking bench, NCH=4, PRE_W=2
// Revision 1.0
// ============================================================================
module tb_ucom_timer_bank;

  localparam int NCH   = 4;
  localparam int CNT_W = 6;
  localparam int PRE_W = 2;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             wr;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_val;
  logic             wr_mode;
  logic             wr_ie;
  logic             ack;
  logic [CH_W-1:0]  ack_ch;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_cnt;
  logic [NCH-1:0]   tm;
  logic [NCH-1:0]   run;
  logic [NCH-1:0]   ovr;
  logic             irq;

  int errors = 0;
  int checks = 0;

  ucom_timer_bank #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .wr(wr), .wr_ch(wr_ch), .wr_val(wr_val), .wr_mode(wr_mode), .wr_ie(wr_ie),
    .ack(ack), .ack_ch(ack_ch), .rd_ch(rd_ch), .rd_cnt(rd_cnt),
    .tm(tm), .run(run), .ovr(ovr), .irq(irq)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: called at a negedge, return at the negedge after the strobe edge
  task automatic do_load(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] v,
                         input logic m, input logic e);
    wr = 1'b1; wr_ch = ch; wr_val = v; wr_mode = m; wr_ie = e;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_ack(input logic [CH_W-1:0] ch);
    ack = 1'b1; ack_ch = ch;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    step(2);
    rd_ch = 3'd0; #1;
    checks++; if (tm !== 4'b0000) begin errors++; $display("FAIL reset_tm: got %b expected 0000", tm); end
    checks++; if (run !== 4'b0000) begin errors++; $display("FAIL reset_run: got %b expected 0000", run); end
    checks++; if (ovr !== 4'b0000) begin errors++; $display("FAIL reset_ovr: got %b expected 0000", ovr); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (rd_cnt !== 6'd0) begin errors++; $display("FAIL reset_rdcnt: got %0d expected 0", rd_cnt); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    do_load(3'd0, 6'd3, 1'b0, 1'b1);
    rd_ch = 3'd0; #1;
    checks++; if (run[0] !== 1'b1) begin errors++; $display("FAIL os_run: got %b expected 1", run[0]); end
    checks++; if (rd_cnt !== 6'd3) begin errors++; $display("FAIL os_load_cnt: got %0d expected 3", rd_cnt); end
    step(15);
    checks++; if (tm[0] !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL os_early: got tm=%b irq=%b expected 0 0", tm[0], irq); end
    step(1);
    checks++; if (tm[0] !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL os_expire: got tm=%b irq=%b expected 1 1", tm[0], irq); end
    checks++; if (run[0] !== 1'b0) begin errors++; $display("FAIL os_stop: got %b expected 0", run[0]); end
    checks++; if (rd_cnt !== 6'd0) begin errors++; $display("FAIL os_cnt_end: got %0d expected 0", rd_cnt); end
    do_ack(3'd0);
    checks++; if (irq !== 1'b0 || tm[0] !== 1'b1) begin errors++; $display("FAIL os_ack: got irq=%b tm=%b expected 0 1", irq, tm[0]); end
    step(20);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_no_reirq: got %b expected 0", irq); end
  endtask

  task automatic test_autoreload();
    do_load(3'd1, 6'd1, 1'b1, 1'b1);
    step(7);
    checks++; if (tm[1] !== 1'b0) begin errors++; $display("FAIL ar_early: got %b expected 0", tm[1]); end
    step(1);
    checks++; if (tm[1] !== 1'b1 || irq !== 1'b1 || ovr[1] !== 1'b0) begin errors++; $display("FAIL ar_exp1: got tm=%b irq=%b ovr=%b expected 1 1 0", tm[1], irq, ovr[1]); end
    do_ack(3'd1);
    checks++; if (irq !== 1'b0 || tm[1] !== 1'b1) begin errors++; $display("FAIL ar_ack1: got irq=%b tm=%b expected 0 1", irq, tm[1]); end
    step(7);
    checks++; if (irq !== 1'b1 || ovr[1] !== 1'b0 || run[1] !== 1'b1) begin errors++; $display("FAIL ar_exp2: got irq=%b ovr=%b run=%b expected 1 0 1", irq, ovr[1], run[1]); end
    step(8);
    checks++; if (ovr[1] !== 1'b1) begin errors++; $display("FAIL ar_overrun: got %b expected 1", ovr[1]); end
    do_ack(3'd1);
    checks++; if (ovr[1] !== 1'b0 || irq !== 1'b0 || tm[1] !== 1'b1) begin errors++; $display("FAIL ar_ack2: got ovr=%b irq=%b tm=%b expected 0 0 1", ovr[1], irq, tm[1]); end
    do_load(3'd1, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_tick_gating();
    tick = 1'b0;
    do_load(3'd2, 6'd0, 1'b0, 1'b1);
    repeat (3) tick_cycle();
    checks++; if (tm[2] !== 1'b0) begin errors++; $display("FAIL tk_early: got %b expected 0", tm[2]); end
    tick_cycle();
    checks++; if (tm[2] !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL tk_expire: got tm=%b irq=%b expected 1 1", tm[2], irq); end
    do_ack(3'd2);
    repeat (3) tick_cycle();
    do_load(3'd2, 6'd2, 1'b0, 1'b1);
    rd_ch = 3'd2; #1;
    checks++; if (tm[2] !== 1'b0 || run[2] !== 1'b1 || rd_cnt !== 6'd2) begin errors++; $display("FAIL tk_reload: got tm=%b run=%b cnt=%0d expected 0 1 2", tm[2], run[2], rd_cnt); end
    repeat (11) tick_cycle();
    checks++; if (tm[2] !== 1'b0) begin errors++; $display("FAIL tk_reload_early: got %b expected 0", tm[2]); end
    tick_cycle();
    checks++; if (tm[2] !== 1'b1) begin errors++; $display("FAIL tk_reload_exp: got %b expected 1", tm[2]); end
    do_ack(3'd2);
    tick = 1'b1;
  endtask

  task automatic test_collisions();
    do_load(3'd3, 6'd0, 1'b1, 1'b1);
    step(3);
    do_ack(3'd3);
    checks++; if (irq !== 1'b1 || tm[3] !== 1'b1 || ovr[3] !== 1'b0) begin errors++; $display("FAIL col_ack_exp: got irq=%b tm=%b ovr=%b expected 1 1 0", irq, tm[3], ovr[3]); end
    do_ack(3'd3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL col_ack_after: got %b expected 0", irq); end
    do_load(3'd3, 6'd0, 1'b0, 1'b0);
    do_load(3'd0, 6'd0, 1'b0, 1'b1);
    step(3);
    do_load(3'd0, 6'd9, 1'b1, 1'b0);
    rd_ch = 3'd0; #1;
    checks++; if (tm[0] !== 1'b0 || run[0] !== 1'b1 || rd_cnt !== 6'd9) begin errors++; $display("FAIL col_load_exp: got tm=%b run=%b cnt=%0d expected 0 1 9", tm[0], run[0], rd_cnt); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL col_load_irq: got %b expected 0", irq); end
  endtask

  task automatic test_reset_midrun();
    do_load(3'd3, 6'd0, 1'b1, 1'b1);
    step(4);
    checks++; if (irq !== 1'b1 || run !== 4'b1001) begin errors++; $display("FAIL rm_pre: got irq=%b run=%b expected 1 1001", irq, run); end
    step(1);
    #2 reset = 1'b1;
    #1;
    checks++; if (tm !== 4'b0 || run !== 4'b0 || ovr !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL rm_async: got tm=%b run=%b ovr=%b irq=%b expected all 0", tm, run, ovr, irq); end
    @(negedge clk);
    reset = 1'b0;
    step(40);
    checks++; if (tm !== 4'b0 || run !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL rm_after: got tm=%b run=%b irq=%b expected all 0", tm, run, irq); end
  endtask

  task automatic test_out_of_range();
    tick = 1'b0;
    do_load(3'd5, 6'd4, 1'b1, 1'b1);
    checks++; if (run !== 4'b0 || tm !== 4'b0) begin errors++; $display("FAIL oor_wr_idle: got run=%b tm=%b expected 0 0", run, tm); end
    do_load(3'd0, 6'd7, 1'b0, 1'b1);
    do_load(3'd5, 6'd1, 1'b1, 1'b1);
    rd_ch = 3'd0; #1;
    checks++; if (rd_cnt !== 6'd7 || run !== 4'b0001) begin errors++; $display("FAIL oor_wr_run: got cnt=%0d run=%b expected 7 0001", rd_cnt, run); end
    rd_ch = 3'd6; #1;
    checks++; if (rd_cnt !== 6'd0) begin errors++; $display("FAIL oor_rd: got %0d expected 0", rd_cnt); end
    @(negedge clk);
    tick = 1'b1;
    step(32);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oor_exp: got %b expected 1", irq); end
    do_ack(3'd7);
    checks++; if (irq !== 1'b1 || ovr !== 4'b0) begin errors++; $display("FAIL oor_ack: got irq=%b ovr=%b expected 1 0000", irq, ovr); end
    do_ack(3'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oor_ack_ok: got %b expected 0", irq); end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1;
    wr = 1'b0; wr_ch = '0; wr_val = '0; wr_mode = 1'b0; wr_ie = 1'b0;
    ack = 1'b0; ack_ch = '0; rd_ch = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_tick_gating();
    test_collisions();
    test_reset_midrun();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
